syst_ws_pe: RTL

- Next-generation weight-stationary processing element for the systolic array in labs/21_syst_ws.
- Adds the following over the basic node:
  - valid-qualified activation and partial-sum flow
  - double-buffered (shadow/active) weights, daisy-chain loaded down a column
  - signed/unsigned arithmetic
  - optional saturation
  - global stall enable
- Tiles into an R x C grid: x and x_vld flow east, psum and psum_vld flow south, w and w_ld flow south through the shadow chain, swap flows south as a wavefront.

---
 rtl/syst_pkg.sv | 20 ++
 rtl/syst_mac.sv | 36 +++
 rtl/syst_ws_pe.sv | 79 +++++++
 3 files changed

// File: rtl/syst_pkg.sv
// syst_pkg: shared widths and saturate/truncate helper for the weight-stationary systolic array
package syst_pkg;
  localparam int W_WIDTH = 8;
  localparam int X_WIDTH = 8;
  localparam int SI_WIDTH = 20;
  localparam int SO_WIDTH = 20;
  localparam int PROD_WIDTH = X_WIDTH + W_WIDTH;
  // Clamps value (already sign- or zero-extended to 64 bits) into width bits, then masks to width.
  function automatic logic signed [63:0] sat_trunc(
    input logic signed [63:0] value,
    input int                 width,
    input logic               signed_mode
  );
    logic signed [63:0] hi, lo, c;
    hi = signed_mode ? (64'sd1 <<< (width - 1)) - 64'sd1 : (64'sd1 <<< width) - 64'sd1;
    lo = signed_mode ? -(64'sd1 <<< (width - 1)) : 64'sd0;
    c = value > hi ? hi : value < lo ? lo : value;
    return c & ((64'sd1 <<< width) - 64'sd1);
  endfunction
endpackage

// File: rtl/syst_mac.sv
// syst_mac: combinational multiply, extend, add and optional saturate for one PE
// Ports: x_i activation, w_i active weight, psum_i/psum_vld_i incoming partial sum
//        (invalid reads as zero), psum_o SO_WIDTH result (wrapped or clamped).
module syst_mac
  import syst_pkg::*;
#(
  parameter int W_WIDTH  = syst_pkg::W_WIDTH,
  parameter int X_WIDTH  = syst_pkg::X_WIDTH,
  parameter int SI_WIDTH = syst_pkg::SI_WIDTH,
  parameter int SO_WIDTH = syst_pkg::SO_WIDTH,
  parameter int SIGNED   = 0,
  parameter int SAT      = 0
) (
  input  logic [X_WIDTH-1:0]  x_i,
  input  logic [W_WIDTH-1:0]  w_i,
  input  logic [SI_WIDTH-1:0] psum_i,
  input  logic                psum_vld_i,
  output logic [SO_WIDTH-1:0] psum_o
);
  localparam int P = X_WIDTH + W_WIDTH;
  localparam int E = SO_WIDTH + 1;
  localparam logic SG = SIGNED != 0;
  logic [P-1:0] xs, ws, prod;
  logic [E-1:0] pe, ae, sum;
  logic [SO_WIDTH-1:0] sat_v;
  always_comb begin
    xs = {{W_WIDTH{SG & x_i[X_WIDTH-1]}}, x_i};
    ws = {{X_WIDTH{SG & w_i[W_WIDTH-1]}}, w_i};
    prod = xs * ws;
    pe = {{(E-P){SG & prod[P-1]}}, prod};
    ae = psum_vld_i ? {{(E-SI_WIDTH){SG & psum_i[SI_WIDTH-1]}}, psum_i} : '0;
    sum = pe + ae;
    sat_v = SO_WIDTH'(sat_trunc({{(64-E){SG & sum[E-1]}}, sum}, SO_WIDTH, SG));
    psum_o = SAT != 0 ? sat_v : sum[SO_WIDTH-1:0];
  end
endmodule

// File: rtl/syst_ws_pe.sv
// syst_ws_pe: weight-stationary PE with valid-qualified flow, double-buffered weights and stall
// Ports: clk/rst_n (sync, active-low), en global stall; x_i/x_vld_i -> x_o/x_vld_o east;
//        psum_i/psum_vld_i -> psum_o/psum_vld_o south; w_i/w_ld_i -> w_o (shadow)/w_ld_o
//        down the load chain; swap_i -> swap_o wavefront; w_act_o active weight.
module syst_ws_pe
  import syst_pkg::*;
#(
  parameter int W_WIDTH  = syst_pkg::W_WIDTH,
  parameter int X_WIDTH  = syst_pkg::X_WIDTH,
  parameter int SI_WIDTH = syst_pkg::SI_WIDTH,
  parameter int SO_WIDTH = syst_pkg::SO_WIDTH,
  parameter int SIGNED   = 0,
  parameter int SAT      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [X_WIDTH-1:0]  x_i,
  input  logic                x_vld_i,
  output logic [X_WIDTH-1:0]  x_o,
  output logic                x_vld_o,
  input  logic [SI_WIDTH-1:0] psum_i,
  input  logic                psum_vld_i,
  output logic [SO_WIDTH-1:0] psum_o,
  output logic                psum_vld_o,
  input  logic [W_WIDTH-1:0]  w_i,
  input  logic                w_ld_i,
  output logic [W_WIDTH-1:0]  w_o,
  output logic                w_ld_o,
  input  logic                swap_i,
  output logic                swap_o,
  output logic [W_WIDTH-1:0]  w_act_o
);
  logic [X_WIDTH-1:0] x_q;
  logic [SO_WIDTH-1:0] psum_q, psum_d, mac_sum;
  logic [W_WIDTH-1:0] sh_q, sh_d, act_q, act_d;
  logic x_vld_q, psum_vld_q, w_ld_q, swap_q;
  syst_mac #(
    .W_WIDTH(W_WIDTH), .X_WIDTH(X_WIDTH), .SI_WIDTH(SI_WIDTH),
    .SO_WIDTH(SO_WIDTH), .SIGNED(SIGNED), .SAT(SAT)
  ) u_mac (
    .x_i(x_i), .w_i(act_q), .psum_i(psum_i), .psum_vld_i(psum_vld_i), .psum_o(mac_sum)
  );
  // MAC uses the pre-swap active weight; swap copies the pre-load shadow.
  always_comb begin
    psum_d = x_vld_i ? mac_sum : psum_q;
    sh_d = w_ld_i ? w_i : sh_q;
    act_d = swap_i ? sh_q : act_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q <= '0;
      x_vld_q <= 1'b0;
      psum_q <= '0;
      psum_vld_q <= 1'b0;
      sh_q <= '0;
      act_q <= '0;
      w_ld_q <= 1'b0;
      swap_q <= 1'b0;
    end else if (en) begin
      x_q <= x_i;
      x_vld_q <= x_vld_i;
      psum_q <= psum_d;
      psum_vld_q <= x_vld_i;
      sh_q <= sh_d;
      act_q <= act_d;
      w_ld_q <= w_ld_i;
      swap_q <= swap_i;
    end
  end
  assign x_o = x_q;
  assign x_vld_o = x_vld_q;
  assign psum_o = psum_q;
  assign psum_vld_o = psum_vld_q;
  assign w_o = sh_q;
  assign w_ld_o = w_ld_q;
  assign swap_o = swap_q;
  assign w_act_o = act_q;
endmodule
